morse_sequencer: RTL and testbench

- Downstream consumer of the rate-divider Enable pulse.
- Plays one Morse letter (A–H) on a single LED. Each Tick advances the output by one time unit: dot = 1 unit on, dash = 3 units on, 1 unit off between symbols.
- Sits between the rate divider (source of Tick, configured for 0.5 s) and the board LED / status logic.

---
 rtl/morse_pkg.sv | 22 ++
 rtl/morse_rom.sv | 36 +++
 rtl/morse_sequencer.sv | 108 ++++++++++
 tb/tb_morse_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared constants and state encoding for the Morse letter sequencer.
package morse_pkg;

    localparam int PATTERN_W_DEF = 12;
    localparam int LEN_W_DEF     = 4;

    localparam logic [2:0] LTR_A = 3'd0;
    localparam logic [2:0] LTR_B = 3'd1;
    localparam logic [2:0] LTR_C = 3'd2;
    localparam logic [2:0] LTR_D = 3'd3;
    localparam logic [2:0] LTR_E = 3'd4;
    localparam logic [2:0] LTR_F = 3'd5;
    localparam logic [2:0] LTR_G = 3'd6;
    localparam logic [2:0] LTR_H = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SEND  = 2'd2
    } state_t;

endpackage

// File: rtl/morse_rom.sv
// Letter -> left-aligned on/off pattern (one bit per time unit) and its length.
module morse_rom
    import morse_pkg::*;
#(
    parameter int PATTERN_W = PATTERN_W_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic [2:0]           Letter,
    output logic [PATTERN_W-1:0] Pattern,
    output logic [LEN_W-1:0]     Len
);

    logic [11:0] pat12;
    logic [3:0]  len4;

    always_comb begin
        pat12 = 12'b0;
        len4  = 4'd0;
        case (Letter)
            LTR_A: begin pat12 = 12'b101110000000; len4 = 4'd5;  end
            LTR_B: begin pat12 = 12'b111010101000; len4 = 4'd9;  end
            LTR_C: begin pat12 = 12'b111010111010; len4 = 4'd11; end
            LTR_D: begin pat12 = 12'b111010100000; len4 = 4'd7;  end
            LTR_E: begin pat12 = 12'b100000000000; len4 = 4'd1;  end
            LTR_F: begin pat12 = 12'b101011101000; len4 = 4'd9;  end
            LTR_G: begin pat12 = 12'b111011101000; len4 = 4'd9;  end
            LTR_H: begin pat12 = 12'b101010100000; len4 = 4'd7;  end
            default: begin pat12 = 12'b0; len4 = 4'd0; end
        endcase
    end

    // Table is written 12 bits wide; wider registers keep it MSB-aligned.
    assign Pattern = PATTERN_W'(pat12) << (PATTERN_W - 12);
    assign Len     = LEN_W'(len4);

endmodule

// File: rtl/morse_sequencer.sv
// Plays one Morse letter on LedOut, advancing one time unit per Tick pulse.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int PATTERN_W = PATTERN_W_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Start,
    input  logic [2:0] Letter,
    output logic       LedOut,
    output logic       Busy,
    output logic       Done,
    output logic [1:0] DbgState
);

    state_t                 state_q, state_d;
    logic [PATTERN_W-1:0]   sreg_q, sreg_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    logic                   led_q, led_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   start_q;
    logic                   start_edge;
    logic [PATTERN_W-1:0]   rom_pattern;
    logic [LEN_W-1:0]       rom_len;

    morse_rom #(
        .PATTERN_W(PATTERN_W),
        .LEN_W    (LEN_W)
    ) u_rom (
        .Letter (Letter),
        .Pattern(rom_pattern),
        .Len    (rom_len)
    );

    assign start_edge = Start & ~start_q;

    always_ff @(posedge ClockIn) begin
        if (!Reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            rem_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            rem_q   <= rem_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= Start;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        rem_d   = rem_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                led_d = 1'b0;
                // A Tick coinciding with acceptance is deliberately not consumed.
                if (start_edge) begin
                    sreg_d  = rom_pattern;
                    rem_d   = rom_len;
                    busy_d  = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED, SEND: begin
                if (Tick) begin
                    if (rem_q != '0) begin
                        led_d   = sreg_q[PATTERN_W-1];
                        sreg_d  = {sreg_q[PATTERN_W-2:0], 1'b0};
                        rem_d   = rem_q - LEN_W'(1);
                        state_d = SEND;
                    end else begin
                        // Trailing off unit closes the letter.
                        led_d   = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                led_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign LedOut   = led_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: directed scenarios plus random traffic vs a queue model.
module tb_morse_sequencer;

  logic       ClockIn;
  logic       Reset;
  logic       Tick;
  logic       Start;
  logic [2:0] Letter;
  logic       LedOut;
  logic       Busy;
  logic       Done;
  logic [1:0] DbgState;

  logic [2:0]  rom_letter;
  logic [11:0] rom_pattern;
  logic [3:0]  rom_len;

  morse_sequencer dut (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .Tick    (Tick),
    .Start   (Start),
    .Letter  (Letter),
    .LedOut  (LedOut),
    .Busy    (Busy),
    .Done    (Done),
    .DbgState(DbgState)
  );

  morse_rom u_rom (
    .Letter (rom_letter),
    .Pattern(rom_pattern),
    .Len    (rom_len)
  );

  // clock / reset
  initial ClockIn = 1'b0;
  always #5 ClockIn = ~ClockIn;

  // reference: letter table as text, one character per time unit
  string pat_tbl [8] = '{"10111", "111010101", "11101011101", "1110101",
                         "1", "101011101", "111011101", "1010101"};

  logic [0:0] exp_q[$];
  logic       m_led, m_busy, m_done, m_prev_start;

  int total_checks = 0;
  int pass_checks  = 0;
  int done_seen    = 0;

  logic       cur_reset;
  logic       cur_start;
  logic [2:0] cur_letter;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp) pass_checks++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // one clock of the behavioural model, evaluated with the inputs seen at the edge
  task automatic model_edge(input logic rst, input logic st, input logic tk, input logic [2:0] ltr);
    logic edge_seen;
    if (!rst) begin
      exp_q.delete();
      m_led = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_prev_start = 1'b0;
    end else begin
      edge_seen    = st & ~m_prev_start;
      m_prev_start = st;
      m_done       = 1'b0;
      if (!m_busy) begin
        m_led = 1'b0;
        if (edge_seen) begin
          for (int i = 0; i < pat_tbl[ltr].len(); i++)
            exp_q.push_back(pat_tbl[ltr][i] == "1");
          m_busy = 1'b1;
        end
      end else if (tk) begin
        if (exp_q.size() > 0) begin
          m_led = exp_q.pop_front();
        end else begin
          m_led = 1'b0; m_done = 1'b1; m_busy = 1'b0;
        end
      end
    end
  endtask

  // driver: apply inputs for one cycle, advance model, compare on the falling edge
  task automatic step(input logic tk);
    Reset = cur_reset; Start = cur_start; Letter = cur_letter; Tick = tk;
    @(posedge ClockIn);
    model_edge(cur_reset, cur_start, tk, cur_letter);
    @(negedge ClockIn);
    check("led", LedOut, m_led);
    check("busy", Busy, m_busy);
    check("done", Done, m_done);
    check("state_idle", DbgState == 2'd0, !m_busy);
    if (Done) done_seen++;
    Tick = 1'b0;
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      repeat (gap - 1) step(1'b0);
      step(1'b1);
    end
  endtask

  task automatic start_letter(input logic [2:0] ltr);
    cur_letter = ltr; cur_start = 1'b1;
    step(1'b0);
    cur_start = 1'b0;
  endtask

  initial begin
    int d0;
    logic [10:0] cap;
    logic [11:0] exp_pat;

    Reset = 1'b0; Start = 1'b0; Tick = 1'b0; Letter = 3'd0;
    cur_reset = 1'b0; cur_start = 1'b0; cur_letter = 3'd0;
    m_led = 0; m_busy = 0; m_done = 0; m_prev_start = 0;
    @(negedge ClockIn);

    // ROM table, every letter
    for (int l = 0; l < 8; l++) begin
      rom_letter = 3'(l);
      exp_pat = '0;
      for (int i = 0; i < pat_tbl[l].len(); i++) exp_pat[11-i] = (pat_tbl[l][i] == "1");
      #1;
      check($sformatf("rom_pat_%0d", l), rom_pattern, exp_pat);
      check($sformatf("rom_len_%0d", l), rom_len, pat_tbl[l].len());
    end

    // reset held with Start high and random Tick
    cur_reset = 1'b0; cur_start = 1'b1;
    repeat (3) step(1'($urandom_range(0, 1)));
    cur_reset = 1'b1; cur_start = 1'b0;
    repeat (8) step(1'($urandom_range(0, 1)));
    check("no_start_after_reset", done_seen, 0);

    // letter E, Tick every 5 clocks
    d0 = done_seen;
    start_letter(3'd4);
    run_ticks(2, 5);
    repeat (3) step(1'b0);
    check("e_done_count", done_seen - d0, 1);

    // letter C, capture LED after each Tick
    d0 = done_seen;
    start_letter(3'd2);
    for (int k = 0; k < 12; k++) begin
      repeat (2) step(1'b0);
      step(1'b1);
      if (k < 11) cap[10-k] = LedOut;
    end
    check("c_sequence", cap, 11'b11101011101);
    check("c_done_count", done_seen - d0, 1);

    // A, with a second Start (Letter H) while busy
    d0 = done_seen;
    start_letter(3'd0);
    run_ticks(2, 4);
    start_letter(3'd7);
    run_ticks(4, 4);
    run_ticks(12, 3);
    check("a_ignore_busy_done_count", done_seen - d0, 1);

    // Start edge coinciding with Tick in IDLE
    d0 = done_seen;
    cur_letter = 3'd0; cur_start = 1'b1;
    step(1'b1);
    cur_start = 1'b0;
    check("coincident_tick_busy", Busy, 1'b1);
    run_ticks(6, 3);
    check("coincident_done_count", done_seen - d0, 1);

    // B interrupted by reset, then D
    d0 = done_seen;
    start_letter(3'd1);
    run_ticks(4, 3);
    cur_reset = 1'b0; step(1'b0);
    cur_reset = 1'b1;
    run_ticks(3, 3);
    check("b_reset_no_done", done_seen - d0, 0);
    start_letter(3'd3);
    run_ticks(8, 2);
    check("d_done_count", done_seen - d0, 1);

    // back-to-back: new Start the cycle after Done
    d0 = done_seen;
    start_letter(3'd4);
    run_ticks(2, 2);
    start_letter(3'd6);
    run_ticks(10, 2);
    check("back_to_back_done_count", done_seen - d0, 2);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      cur_reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0) cur_start = ~cur_start;
      cur_letter = 3'($urandom_range(0, 7));
      step($urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
